// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between NUM_REQ requesters. One access is
//            issued per cycle, picked round-robin; a requester may lock the
//            port for a burst. Read data returns READ_LATENCY cycles after the
//            accept, tagged with the requester id. Out-of-range addresses are
//            accepted but never reach the memory; reads answer with rsp_err.
// Ports    : clock, reset                 - clock, sync active-high reset
//            req_valid/ready/we/lock      - per-requester handshake + control
//            req_addr/req_wdata           - per-requester word address / data
//            rsp_valid/id/rdata/err       - read response (no backpressure)
//            mem_en/we/addr/din, mem_dout - memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int READ_LATENCY = 2,
   parameter int MEM_WORDS    = 1000
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ-1:0]               req_lock,
   input  logic [NUM_REQ-1:0][31:0]         req_addr,
   input  logic [NUM_REQ-1:0][31:0]         req_wdata,
   output logic                             rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
   output logic [31:0]                      rsp_rdata,
   output logic                             rsp_err,
   output logic                             mem_en,
   output logic                             mem_we,
   output logic [31:0]                      mem_addr,
   output logic [31:0]                      mem_din,
   input  logic [31:0]                      mem_dout
);

   localparam int          c_ID_W      = $clog2(NUM_REQ);
   localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);
   localparam int          c_LAST      = READ_LATENCY - 1;

   typedef enum logic [0:0] {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_ID_W-1:0]    r_ptr;
   logic [c_ID_W-1:0]    w_ptr_nxt;
   logic [c_ID_W-1:0]    r_owner;
   logic [c_ID_W-1:0]    w_owner_nxt;

   logic                 w_grant;
   logic [c_ID_W-1:0]    w_gid;
   logic [c_ID_W:0]      w_sum;     // one extra bit so ptr+i can be wrapped
   logic                 w_in_range;

   // Response pipeline: stage 0 loads on an accepted read, stage c_LAST
   // lines up with mem_dout for that read.
   logic [READ_LATENCY-1:0]             r_pv;
   logic [READ_LATENCY-1:0]             r_perr;
   logic [READ_LATENCY-1:0][c_ID_W-1:0] r_pid;

   // -------------------------------------------------------------------------
   // Grant selection and next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_grant     = 1'b0;
      w_gid       = '0;
      w_sum       = '0;
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;

      if (!reset) begin
         if (r_state == ST_LOCKED) begin
            if (req_valid[r_owner]) begin
               w_grant = 1'b1;
               w_gid   = r_owner;
            end
         end else begin
            // Scan from the far end back to ptr so the candidate nearest to
            // ptr is the last one written and therefore wins.
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
               w_sum = {1'b0, r_ptr} + (c_ID_W + 1)'(i);
               if (w_sum >= (c_ID_W + 1)'(NUM_REQ)) begin
                  w_sum = w_sum - (c_ID_W + 1)'(NUM_REQ);
               end
               if (req_valid[w_sum[c_ID_W-1:0]]) begin
                  w_grant = 1'b1;
                  w_gid   = w_sum[c_ID_W-1:0];
               end
            end
         end

         if (w_grant) begin
            w_ptr_nxt = (w_gid == c_ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
            if (req_lock[w_gid]) begin
               w_state_nxt = ST_LOCKED;
               w_owner_nxt = w_gid;
            end else begin
               w_state_nxt = ST_ARB;
            end
         end else begin
            // An idle owner gives the lock up; the pointer already sits past it.
            w_state_nxt = ST_ARB;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_ARB;
         r_ptr   <= '0;
         r_owner <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Handshake and memory port
   // -------------------------------------------------------------------------
   assign w_in_range = (req_addr[w_gid] < c_MEM_WORDS);

   always_comb begin
      req_ready = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      if (w_grant) begin
         req_ready[w_gid] = 1'b1;
         // Out-of-range accesses are consumed here and never touch memory.
         if (w_in_range) begin
            mem_en   = 1'b1;
            mem_we   = req_we[w_gid];
            mem_addr = req_addr[w_gid];
            mem_din  = req_wdata[w_gid];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read response tracking
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pv   <= '0;
         r_perr <= '0;
         r_pid  <= '0;
      end else begin
         r_pv[0]   <= w_grant & ~req_we[w_gid];
         r_perr[0] <= ~w_in_range;
         r_pid[0]  <= w_gid;
         for (int s = 1; s < READ_LATENCY; s++) begin
            r_pv[s]   <= r_pv[s-1];
            r_perr[s] <= r_perr[s-1];
            r_pid[s]  <= r_pid[s-1];
         end
      end
   end

   // Gated by reset so the response outputs read as idle in any reset cycle.
   assign rsp_valid = r_pv[c_LAST] & ~reset;
   assign rsp_err   = rsp_valid & r_perr[c_LAST];
   assign rsp_id    = rsp_valid ? r_pid[c_LAST] : '0;
   assign rsp_rdata = (rsp_valid && !r_perr[c_LAST]) ? mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural model
//            (rotation index, lock owner, queue of expected responses, shadow
//            memory) predicts every output each cycle; directed phases pin
//            the model with literal values, then random traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int c_N     = 2;
   localparam int c_LAT   = 2;
   localparam int c_WORDS = 1000;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [c_N-1:0]        req_valid;
   logic [c_N-1:0]        req_ready;
   logic [c_N-1:0]        req_we;
   logic [c_N-1:0]        req_lock;
   logic [c_N-1:0][31:0]  req_addr;
   logic [c_N-1:0][31:0]  req_wdata;
   logic                  rsp_valid;
   logic [0:0]            rsp_id;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic                  mem_en;
   logic                  mem_we;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_din;
   logic [31:0]           mem_dout;

   mem_port_arbiter #(
      .NUM_REQ      (c_N),
      .READ_LATENCY (c_LAT),
      .MEM_WORDS    (c_WORDS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // -------------------------------------------------------------------------
   // Memory attached to the port: fixed read latency, garbage when not read
   // so a leaked mem_dout on an error response is visible.
   // -------------------------------------------------------------------------
   logic [31:0] env_mem [0:c_WORDS-1];
   logic [31:0] env_rd  [0:c_LAT-1];

   always @(posedge clock) begin
      if (mem_en && mem_we && mem_addr < 32'd1000) env_mem[mem_addr[9:0]] <= mem_din;
      env_rd[0] <= (mem_en && !mem_we && mem_addr < 32'd1000) ? env_mem[mem_addr[9:0]]
                                                              : 32'hBAD0_BAD0;
      for (int s = 1; s < c_LAT; s++) env_rd[s] <= env_rd[s-1];
   end
   assign mem_dout = env_rd[c_LAT-1];

   // -------------------------------------------------------------------------
   // Reference model and checker
   // -------------------------------------------------------------------------
   typedef struct {
      int          due;
      int          id;
      bit          err;
      logic [31:0] data;
   } exp_t;

   exp_t           exp_q[$];
   logic [31:0]    m_mem [0:c_WORDS-1];
   int             m_ptr   = 0;
   int             m_owner = -1;    // -1: nobody holds the lock
   logic [c_N-1:0] m_acc   = '0;    // accepts predicted for the cycle just sampled
   int             n_tests = 0;
   int             n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      int             g;
      int             k;
      exp_t           e;
      logic [c_N-1:0] x_ready;
      logic           x_en;
      logic           x_we;
      logic           x_rv;
      logic           x_err;
      logic [31:0]    x_rd;
      int             x_id;

      g = -1;
      if (!reset) begin
         if (m_owner >= 0) begin
            if (req_valid[m_owner]) g = m_owner;
         end else begin
            for (int i = 0; i < c_N; i++) begin
               k = (m_ptr + i) % c_N;
               if (g < 0 && req_valid[k]) g = k;
            end
         end
      end

      x_ready = '0;
      x_en    = 1'b0;
      x_we    = 1'b0;
      if (g >= 0) begin
         x_ready[g] = 1'b1;
         x_en       = (req_addr[g] < c_WORDS);
         x_we       = x_en & req_we[g];
      end

      x_rv  = 1'b0;
      x_err = 1'b0;
      x_rd  = '0;
      x_id  = 0;
      if (!reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e     = exp_q.pop_front();
         x_rv  = 1'b1;
         x_err = e.err;
         x_rd  = e.data;
         x_id  = e.id;
      end

      chk("req_ready", 32'(req_ready), 32'(x_ready));
      chk("mem_en", 32'(mem_en), 32'(x_en));
      chk("mem_we", 32'(mem_we), 32'(x_we));
      if (x_en) chk("mem_addr", mem_addr, req_addr[g]);
      if (x_we) chk("mem_din", mem_din, req_wdata[g]);
      if (reset) begin
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_din", mem_din, 32'd0);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(x_rv));
      chk("rsp_err", 32'(rsp_err), 32'(x_err));
      chk("rsp_rdata", rsp_rdata, x_rd);
      if (x_rv || reset) chk("rsp_id", 32'(rsp_id), 32'(x_id));

      if (reset) begin
         exp_q.delete();
         m_ptr   = 0;
         m_owner = -1;
         m_acc   = '0;
      end else begin
         m_acc = x_ready;
         if (g >= 0) begin
            m_ptr   = (g + 1) % c_N;
            m_owner = req_lock[g] ? g : -1;
            if (!req_we[g]) begin
               e.due  = cyc + c_LAT;
               e.id   = g;
               e.err  = !x_en;
               e.data = x_en ? m_mem[req_addr[g][9:0]] : 32'd0;
               exp_q.push_back(e);
            end else if (x_en) begin
               m_mem[req_addr[g][9:0]] = req_wdata[g];
            end
         end else begin
            m_owner = -1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      req_valid = '0;
      req_we    = '0;
      req_lock  = '0;
   endtask

   task automatic new_req(input int r);
      req_valid[r] = 1'b1;
      req_we[r]    = ($urandom_range(0, 2) == 0);
      req_lock[r]  = ($urandom_range(0, 2) == 0);
      req_wdata[r] = $urandom;
      case ($urandom_range(0, 9))
         0:       req_addr[r] = 32'(998 + $urandom_range(0, 3));
         1:       req_addr[r] = $urandom;
         default: req_addr[r] = 32'($urandom_range(0, 31));
      endcase
   endtask

   initial begin
      logic [31:0] v;
      logic [1:0]  exp_rdy;

      reset     = 1'b1;
      req_valid = '1;
      req_we    = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < c_WORDS; i++) begin
         v = (i == 5) ? 32'hDEAD_BEEF : $urandom;
         env_mem[i] <= v;
         m_mem[i]    = v;
      end

      // Reset held three cycles with every requester asking.
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("p0_ready", 32'(req_ready), 32'd0);
         chk("p0_mem_en", 32'(mem_en), 32'd0);
         chk("p0_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      tick();
      reset = 1'b0;
      idle();

      // Single read of address 5.
      tick();
      req_valid = 2'b01;
      req_addr[0] = 32'd5;
      @(negedge clock);
      chk("p1_ready", 32'(req_ready), 32'd1);
      chk("p1_mem_addr", mem_addr, 32'd5);
      tick();
      idle();
      @(negedge clock);
      chk("p1_rsp_early", 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clock);
      chk("p1_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("p1_rsp_id", 32'(rsp_id), 32'd0);
      chk("p1_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("p1_rsp_err", 32'(rsp_err), 32'd0);
      tick();
      @(negedge clock);
      chk("p1_rsp_late", 32'(rsp_valid), 32'd0);

      // Write then read address 7 from requester 1.
      tick();
      req_valid    = 2'b10;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'd7;
      req_wdata[1] = 32'h1234_5678;
      @(negedge clock);
      chk("p2_wr_ready", 32'(req_ready), 32'd2);
      chk("p2_mem_we", 32'(mem_we), 32'd1);
      chk("p2_mem_din", mem_din, 32'h1234_5678);
      tick();
      req_we[1] = 1'b0;
      @(negedge clock);
      chk("p2_rd_ready", 32'(req_ready), 32'd2);
      tick();
      idle();
      tick();
      @(negedge clock);
      chk("p2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("p2_rsp_id", 32'(rsp_id), 32'd1);
      chk("p2_rsp_rdata", rsp_rdata, 32'h1234_5678);

      // Fairness: both reading every cycle, strict alternation from 0.
      tick();
      req_valid   = 2'b11;
      req_addr[0] = 32'($urandom_range(0, 999));
      req_addr[1] = 32'($urandom_range(0, 999));
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         exp_rdy = (k >= 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
         chk("p3_grant", 32'(req_ready), 32'(exp_rdy));
         if (k >= 2) begin
            chk("p3_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("p3_rsp_id", 32'(rsp_id), 32'(k % 2));
         end
         tick();
         if (k >= 7) idle();
         else req_addr[k % 2] = 32'($urandom_range(0, 999));
      end

      // Lock burst: requester 0 alone first so the pointer moves to 1.
      req_valid   = 2'b01;
      req_addr[0] = 32'd11;
      @(negedge clock);
      chk("p4_pre", 32'(req_ready), 32'd1);
      tick();
      req_valid   = 2'b11;
      req_addr[0] = 32'd12;
      req_addr[1] = 32'd20;
      req_lock[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("p4_locked", 32'(req_ready), 32'd2);
         tick();
         req_addr[1] = 32'(21 + k);
         req_lock[1] = (k < 2);
      end
      req_valid = 2'b01;
      req_lock  = '0;
      @(negedge clock);
      chk("p4_release", 32'(req_ready), 32'd1);
      tick();
      idle();

      // Boundary: out-of-range read, out-of-range write, reset kills response.
      tick();
      req_valid   = 2'b01;
      req_addr[0] = 32'd1000;
      @(negedge clock);
      chk("p5_ready", 32'(req_ready), 32'd1);
      chk("p5_mem_en", 32'(mem_en), 32'd0);
      tick();
      req_valid    = 2'b10;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'd1000;
      @(negedge clock);
      chk("p5_wr_mem_en", 32'(mem_en), 32'd0);
      tick();
      idle();
      @(negedge clock);
      chk("p5_err_valid", 32'(rsp_valid), 32'd1);
      chk("p5_err_flag", 32'(rsp_err), 32'd1);
      chk("p5_err_rdata", rsp_rdata, 32'd0);
      chk("p5_err_id", 32'(rsp_id), 32'd0);
      tick();
      req_valid   = 2'b01;
      req_addr[0] = 32'd1000;
      @(negedge clock);
      chk("p5_ready2", 32'(req_ready), 32'd1);
      tick();
      idle();
      reset = 1'b1;
      @(negedge clock);
      chk("p5_rst_cycle", 32'(rsp_valid), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("p5_rst_drop", 32'(rsp_valid), 32'd0);

      // Random traffic with occasional resets; requests held until accepted.
      for (int c = 0; c < 2000; c++) begin
         tick();
         reset = ($urandom_range(0, 299) == 0);
         for (int r = 0; r < c_N; r++) begin
            if (!(req_valid[r] && !m_acc[r])) begin
               if ($urandom_range(0, 3) != 0) new_req(r);
               else req_valid[r] = 1'b0;
            end
         end
      end
      tick();
      reset = 1'b0;
      idle();
      for (int k = 0; k < 4; k++) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
